// File: rtl/lzd_arbiter_48.sv
// Two-requester round-robin front end for one shared 48-bit leading-zero detector/normaliser.
// Latency: operand handshake at cycle N gives out_valid at cycle N+2; one operand per 3 cycles at best.
// Backpressure: result holds in RESP until out_ready; requests stay pending (ready low) while busy.

// Combinational 48-bit leading-zero detector: counts zeros from bit 47 down.
module lzd48 (
  input  logic [47:0] din,
  output logic [5:0]  lz,
  output logic        zero
);

  // Scan upward so the highest set bit makes the final assignment.
  always_comb begin
    lz   = '0;
    zero = (din == '0);
    for (int i = 0; i < 48; i++) begin
      if (din[i]) lz = 6'(47 - i);
    end
  end

endmodule

module lzd_arbiter_48 #(
  parameter logic       RR_INIT = 1'b0,
  parameter logic [5:0] ZERO_LZ = 6'd48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [47:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [47:0] req1_data,
  output logic        req1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_lz,
  output logic [47:0] out_norm,
  output logic        out_zero,
  output logic        out_tag,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [47:0] op_q;
  logic        tag_q;
  logic        last_q;     // last grantee; the other side wins a tie
  logic        grant_any;
  logic        grant_sel;
  logic        take;
  logic [5:0]  lzd_lz;
  logic        lzd_zero;
  logic [47:0] lzd_norm;

  // Single shared detector, always fed from the latched operand.
  lzd48 u_lzd (
    .din  (op_q),
    .lz   (lzd_lz),
    .zero (lzd_zero)
  );

  // A zero operand yields lz = 0 from the detector, so the shift gives 0 as required.
  assign lzd_norm = op_q << lzd_lz;

  // Arbitration: lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_sel = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  end

  // Next-state and handshake outputs; ready is only ever raised in IDLE outside reset.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    take       = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant_any && !reset) begin
          take       = 1'b1;
          req0_ready = ~grant_sel;
          req1_ready = grant_sel;
          state_nxt  = CALC;
        end
      end
      CALC: state_nxt = RESP;
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset drops any in-flight operand by returning to IDLE.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand/tag capture at grant and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      tag_q  <= 1'b0;
      last_q <= ~RR_INIT;
    end else if (take) begin
      op_q   <= grant_sel ? req1_data : req0_data;
      tag_q  <= grant_sel;
      last_q <= grant_sel;
    end
  end

  // Result registers load only in CALC, so they hold through RESP and afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_lz   <= '0;
      out_norm <= '0;
      out_zero <= 1'b0;
      out_tag  <= 1'b0;
    end else if (state == CALC) begin
      out_lz   <= lzd_zero ? ZERO_LZ : lzd_lz;
      out_norm <= lzd_norm;
      out_zero <= lzd_zero;
      out_tag  <= tag_q;
    end
  end

endmodule

// File: tb/tb_lzd_arbiter_48.sv
module tb_lzd_arbiter_48;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [47:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        out_valid, out_ready;
  logic [5:0]  out_lz;
  logic [47:0] out_norm;
  logic        out_zero, out_tag, busy;

  int checks = 0;
  int errors = 0;

  lzd_arbiter_48 #(.RR_INIT(1'b0), .ZERO_LZ(6'd48)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_lz     (out_lz),
    .out_norm   (out_norm),
    .out_zero   (out_zero),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [47:0] data;
    logic [5:0]  lz;
    logic [47:0] norm;
    logic        zero;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    step();
    out_ready  = 1'b1;
    req0_valid = ~v.sel;
    req1_valid = v.sel;
    req0_data  = v.sel ? 48'h0 : v.data;
    req1_data  = v.sel ? v.data : 48'h0;
    #1;
    chk("grant_ready0", {63'd0, req0_ready}, {63'd0, ~v.sel});
    chk("grant_ready1", {63'd0, req1_ready}, {63'd0, v.sel});
    step();                       // CALC
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '1;
    req1_data  = '1;
    chk("calc_valid", {63'd0, out_valid}, 64'd0);
    chk("calc_busy",  {63'd0, busy}, 64'd1);
    step();                       // RESP
    chk("resp_valid", {63'd0, out_valid}, 64'd1);
    chk("resp_lz",    {58'd0, out_lz}, {58'd0, v.lz});
    chk("resp_norm",  {16'd0, out_norm}, {16'd0, v.norm});
    chk("resp_zero",  {63'd0, out_zero}, {63'd0, v.zero});
    chk("resp_tag",   {63'd0, out_tag}, {63'd0, v.sel});
    step();                       // back to IDLE, fields hold
    chk("idle_busy",  {63'd0, busy}, 64'd0);
    chk("idle_valid", {63'd0, out_valid}, 64'd0);
    chk("hold_lz",    {58'd0, out_lz}, {58'd0, v.lz});
  endtask

  initial begin
    vecs[0] = '{1'b0, 48'h0000_4900_00C9, 6'd17, 48'h9200_0192_0000, 1'b0};
    vecs[1] = '{1'b1, 48'h0000_0000_0000, 6'd48, 48'h0000_0000_0000, 1'b1};
    vecs[2] = '{1'b0, 48'h8000_0000_0000, 6'd0,  48'h8000_0000_0000, 1'b0};
    vecs[3] = '{1'b1, 48'h0000_0000_0001, 6'd47, 48'h8000_0000_0000, 1'b0};
    vecs[4] = '{1'b0, 48'h0000_0001_0000, 6'd31, 48'h8000_0000_0000, 1'b0};
    vecs[5] = '{1'b1, 48'h0000_0000_FFFF, 6'd32, 48'hFFFF_0000_0000, 1'b0};
    vecs[6] = '{1'b0, 48'hFFFF_FFFF_FFFF, 6'd0,  48'hFFFF_FFFF_FFFF, 1'b0};
    vecs[7] = '{1'b1, 48'h0000_0000_0003, 6'd46, 48'hC000_0000_0000, 1'b0};

    reset      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 48'h1;
    req1_data  = 48'h2;
    out_ready  = 1'b1;
    step();
    step();
    // Reset state, with both requests asserted: readies must stay low.
    chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
    chk("rst_ready1", {63'd0, req1_ready}, 64'd0);
    chk("rst_valid",  {63'd0, out_valid}, 64'd0);
    chk("rst_busy",   {63'd0, busy}, 64'd0);
    chk("rst_lz",     {58'd0, out_lz}, 64'd0);
    chk("rst_norm",   {16'd0, out_norm}, 64'd0);
    chk("rst_zero",   {63'd0, out_zero}, 64'd0);
    chk("rst_tag",    {63'd0, out_tag}, 64'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Contention straight after reset: grants alternate 0,1,0,1 every 3 cycles.
    @(negedge clk);
    reset = 1'b1;
    step();
    @(negedge clk);
    reset      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 48'h0000_0000_0001;
    req1_data  = 48'h8000_0000_0000;
    out_ready  = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("rr_ready0_c%0d", c), {63'd0, req0_ready}, {63'd0, (c % 6) == 0});
      chk($sformatf("rr_ready1_c%0d", c), {63'd0, req1_ready}, {63'd0, (c % 6) == 3});
      if ((c % 3) == 2) begin
        chk($sformatf("rr_tag_c%0d", c), {63'd0, out_tag}, {63'd0, (c % 6) == 5});
        chk($sformatf("rr_lz_c%0d", c), {58'd0, out_lz}, ((c % 6) == 5) ? 64'd0 : 64'd47);
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();
    step();

    // Backpressure: 5 stalled RESP cycles with a pending request, released on the 6th.
    chk("bp_idle", {63'd0, busy}, 64'd0);
    out_ready  = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 48'h0000_4900_00C9;
    #1;
    chk("bp_grant", {63'd0, req0_ready}, 64'd1);
    step();                       // CALC
    req0_data = 48'h0000_0000_00FF;   // next operand, left pending
    step();                       // first RESP cycle
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid_%0d", c), {63'd0, out_valid}, 64'd1);
      chk($sformatf("bp_lz_%0d", c),    {58'd0, out_lz}, 64'd17);
      chk($sformatf("bp_norm_%0d", c),  {16'd0, out_norm}, 64'h9200_0192_0000);
      chk($sformatf("bp_tag_%0d", c),   {63'd0, out_tag}, 64'd0);
      chk($sformatf("bp_ready_%0d", c), {63'd0, req0_ready}, 64'd0);
      if (c < 4) step();
    end
    step();
    out_ready = 1'b1;             // sixth RESP cycle: release
    #1;
    chk("bp_rel_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_rel_ready", {63'd0, req0_ready}, 64'd0);
    step();                       // IDLE: pending request taken
    chk("bp_next_grant", {63'd0, req0_ready}, 64'd1);
    step();                       // CALC of 0xFF
    req0_valid = 1'b0;
    step();                       // RESP
    chk("bp_next_lz", {58'd0, out_lz}, 64'd40);
    step();

    // Reset during CALC: operand discarded, pointer back to RR_INIT.
    req1_valid = 1'b1;
    req1_data  = 48'h0000_0000_0001;
    #1;
    chk("mid_grant", {63'd0, req1_ready}, 64'd1);
    step();                       // CALC
    req1_valid = 1'b0;
    reset      = 1'b1;
    #1;
    chk("mid_rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("mid_valid_%0d", c), {63'd0, out_valid}, 64'd0);
      chk($sformatf("mid_busy_%0d", c),  {63'd0, busy}, 64'd0);
      step();
    end
    chk("mid_lz_reset", {58'd0, out_lz}, 64'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mid_rr_ready0", {63'd0, req0_ready}, 64'd1);
    chk("mid_rr_ready1", {63'd0, req1_ready}, 64'd0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lzd_arbiter_48.md
LZD_ARBITER_48 -- requirements
Module: lzd_arbiter_48

Interface
REQ-001 Parameter: RR_INIT, 1'b0, requester that wins the first simultaneous request after reset.
REQ-002 Parameter: ZERO_LZ, 6'd48, out_lz value reported for a zero operand.
REQ-003 Clocking: one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req0_valid  in  1  requester 0 (log path) operand valid.
REQ-007 req0_data  in  48  requester 0 operand.
REQ-008 req0_ready  out  1  requester 0 operand accepted this cycle.
REQ-009 req1_valid  in  1  requester 1 (sqrt path) operand valid.
REQ-010 req1_data  in  48  requester 1 operand.
REQ-011 req1_ready  out  1  requester 1 operand accepted this cycle.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 out_lz  out  6  leading-zero count of the accepted operand (0..47, or ZERO_LZ).
REQ-015 out_norm  out  48  operand shifted left by out_lz (MSB = 1 unless zero).
REQ-016 out_zero  out  1  operand was all zeros.
REQ-017 out_tag  out  1  index of the requester that owns the result.
REQ-018 busy  out  1  FSM not in IDLE.

Function
REQ-019 The block SHALL contain one instance of the team's 48-bit leading-zero detector, shared between both requesters; no second LZD.
REQ-020 FSM states SHALL be IDLE, CALC, RESP; encoding free.
REQ-021 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready in the same cycle (combinational from valid and the round-robin pointer), latch operand and tag, go to CALC; otherwise stay.
REQ-022 At most one of req0_ready/req1_ready SHALL be high in any cycle; both SHALL be low outside IDLE.
REQ-023 Arbitration: only one valid -> grant it; both valid -> grant the requester not granted last (pointer = last grantee, initialised to ~RR_INIT at reset).
REQ-024 CALC: one cycle; register out_lz, out_norm, out_zero from the latched operand via the LZD; go to RESP.
REQ-025 RESP: out_valid = 1 with stable out_lz/out_norm/out_zero/out_tag until out_ready = 1; on the cycle out_valid & out_ready, go to IDLE.
REQ-026 Latency: operand handshake at cycle N -> out_valid high at cycle N+2; minimum issue interval 3 cycles.
REQ-027 out_lz SHALL equal the count of consecutive zeros from bit 47 down; operand 48'h8000_0000_0000 -> 0; 48'h1 -> 47.
REQ-028 Zero operand: out_zero = 1, out_lz = ZERO_LZ, out_norm = 0.
REQ-029 out_norm SHALL be operand << out_lz truncated to 48 bits; for nonzero operands out_norm[47] = 1.
REQ-030 Output fields SHALL hold their last value outside RESP; only out_valid qualifies them.
REQ-031 Requests arriving while busy SHALL be left pending (ready low); requesters hold valid/data until ready.
REQ-032 busy SHALL be high in CALC and RESP, low in IDLE.

Reset
REQ-033 reset high at a clock edge SHALL force IDLE, out_valid = 0, out_lz = 0, out_norm = 0, out_zero = 0, out_tag = 0, RR pointer = ~RR_INIT, req0_ready = req1_ready = 0 while reset is high.
REQ-034 Reset in CALC or RESP SHALL discard the in-flight operand; no result is emitted for it.

Verification
REQ-035 Single request: req0_data = 48'h0000_4900_00C9, out_ready = 1 -> req0_ready same cycle, two cycles later out_valid, out_lz = 17, out_norm = 48'h9200_0192_0000, out_tag = 0, then IDLE.
REQ-036 Zero operand: req1_data = 0 -> out_zero = 1, out_lz = 48, out_norm = 0, out_tag = 1.
REQ-037 Contention: both valid continuously after reset (RR_INIT = 0) -> grants alternate 0,1,0,1; one grant per 3 cycles.
REQ-038 Backpressure: out_ready low 5 cycles in RESP -> out_valid and all fields stable 5 cycles, no new ready; released on cycle 6.
REQ-039 Boundaries: operands 48'h8000_0000_0000, 48'h1, 48'h0000_0001_0000, 48'h0000_0000_FFFF -> out_lz 0, 47, 31, 32.
REQ-040 Reset mid-op: reset asserted in CALC -> no out_valid afterwards, busy = 0, next simultaneous request granted to requester RR_INIT.
